vram_term_ctrl: RTL

//  Terminal controller owning port A of the 64x32 character VRAM: accepts a byte stream (e.g. from UART RX),

---
 rtl/vram_term_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/vram_term_ctrl.sv
// Terminal controller owning VRAM port A: interprets a byte stream, writes glyphs
// at the cursor, scrolls the screen up one row and clears it.
module vram_term_ctrl #(
  parameter int unsigned COLS = 60,
  parameter int unsigned ROWS = 17,
  parameter logic [7:0]  FILL = 8'h20
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_rdy,
  output logic [10:0] o_vram_addr,
  output logic [7:0]  o_vram_din,
  input  logic [7:0]  i_vram_dout,
  output logic        o_vram_ce,
  output logic        o_vram_wre,
  output logic [5:0]  o_cur_x,
  output logic [4:0]  o_cur_y
);

  localparam logic [5:0] X_LAST = 6'(COLS - 1);
  localparam logic [4:0] Y_LAST = 5'(ROWS - 1);

  // States name the access issued at the next clock edge; px/py point at that cell.
  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_SRD,
    ST_SWR,
    ST_CLRLINE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  px_q, px_d;
  logic [4:0]  py_q, py_d;
  logic [5:0]  cur_x_q, cur_x_d;
  logic [4:0]  cur_y_q, cur_y_d;

  logic        rdy_q, rdy_d;
  logic        ce_q, ce_d;
  logic        wre_q, wre_d;
  logic        swr_q, swr_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;

  logic        accept;
  logic        is_put;
  logic        newline;
  logic [4:0]  py_prev;

  assign accept  = i_valid & rdy_q;
  assign is_put  = (i_data >= 8'h20);
  assign py_prev = py_q - 5'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_CLEAR;
      px_q    <= '0;
      py_q    <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      rdy_q   <= 1'b0;
      ce_q    <= 1'b0;
      wre_q   <= 1'b0;
      swr_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= FILL;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      rdy_q   <= rdy_d;
      ce_q    <= ce_d;
      wre_q   <= wre_d;
      swr_q   <= swr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    newline = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (px_q == X_LAST) begin
          px_d = '0;
          if (py_q == Y_LAST) begin
            py_d    = '0;
            state_d = ST_IDLE;
          end else begin
            py_d = py_q + 5'd1;
          end
        end else begin
          px_d = px_q + 6'd1;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          case (i_data)
            8'h0D: cur_x_d = '0;
            8'h0A: newline = 1'b1;
            8'h08: if (cur_x_q != '0) cur_x_d = cur_x_q - 6'd1;
            8'h0C: begin
              cur_x_d = '0;
              cur_y_d = '0;
              px_d    = '0;
              py_d    = '0;
              state_d = ST_CLEAR;
            end
            default: begin
              if (is_put) begin
                if (cur_x_q == X_LAST) begin
                  cur_x_d = '0;
                  newline = 1'b1;
                end else begin
                  cur_x_d = cur_x_q + 6'd1;
                end
              end
            end
          endcase
          if (newline) begin
            if (cur_y_q != Y_LAST) begin
              cur_y_d = cur_y_q + 5'd1;
            end else begin
              px_d    = '0;
              py_d    = 5'd1;
              state_d = ST_SRD;
            end
          end
        end
      end
      ST_SRD: state_d = ST_SWR;
      ST_SWR: begin
        if (px_q == X_LAST) begin
          px_d = '0;
          if (py_q == Y_LAST) begin
            state_d = ST_CLRLINE;
          end else begin
            py_d    = py_q + 5'd1;
            state_d = ST_SRD;
          end
        end else begin
          px_d    = px_q + 6'd1;
          state_d = ST_SRD;
        end
      end
      ST_CLRLINE: begin
        if (px_q == X_LAST) begin
          px_d    = '0;
          state_d = ST_IDLE;
        end else begin
          px_d = px_q + 6'd1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    rdy_d  = 1'b0;
    ce_d   = 1'b0;
    wre_d  = 1'b0;
    swr_d  = 1'b0;
    addr_d = {cur_y_q, cur_x_q};
    din_d  = din_q;
    case (state_q)
      ST_CLEAR: begin
        ce_d   = 1'b1;
        wre_d  = 1'b1;
        addr_d = {py_q, px_q};
        din_d  = FILL;
      end
      ST_IDLE: begin
        if (accept) begin
          if (is_put) begin
            ce_d  = 1'b1;
            wre_d = 1'b1;
            din_d = i_data;
          end
        end else begin
          rdy_d = 1'b1;
        end
      end
      ST_SRD: begin
        ce_d   = 1'b1;
        addr_d = {py_q, px_q};
      end
      ST_SWR: begin
        ce_d   = 1'b1;
        wre_d  = 1'b1;
        swr_d  = 1'b1;
        addr_d = {py_prev, px_q};
      end
      ST_CLRLINE: begin
        ce_d   = 1'b1;
        wre_d  = 1'b1;
        addr_d = {Y_LAST, px_q};
        din_d  = FILL;
      end
      default: ;
    endcase
  end

  assign o_rdy       = rdy_q;
  assign o_vram_ce   = ce_q;
  assign o_vram_wre  = wre_q;
  assign o_vram_addr = addr_q;
  // Read data only arrives in the write cycle of a scroll step, so it bypasses din_q there.
  assign o_vram_din  = swr_q ? i_vram_dout : din_q;
  assign o_cur_x     = cur_x_q;
  assign o_cur_y     = cur_y_q;

endmodule
